// File: rtl/gen_fip_max_finder_pkg.sv
// Shared types and helpers for the sequential fixed-point arg-max engine.
package gen_fip_max_finder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } max_fsm_st_t;

  // Larger of two widths, used to align operands of mixed formats.
  function automatic int max_w(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/gen_fip_sign_comperator.sv
// Signed fixed-point comparator: o_res=1 when num1 >= num2, else 0.
// Operands of different formats are aligned on the binary point first.
module gen_fip_sign_comperator
  import gen_fip_max_finder_pkg::*;
#(
  parameter int NUM1_INT_W   = 1,
  parameter int NUM1_FRACT_W = 5,
  parameter int NUM2_INT_W   = 1,
  parameter int NUM2_FRACT_W = 5,
  localparam int NUM1_W      = NUM1_INT_W + NUM1_FRACT_W,
  localparam int NUM2_W      = NUM2_INT_W + NUM2_FRACT_W
) (
  input  logic              i_start_pls,
  input  logic [NUM1_W-1:0] i_num1,
  input  logic [NUM2_W-1:0] i_num2,
  output logic              o_res,
  output logic              o_done_pls
);

  localparam int INT_W   = max_w(NUM1_INT_W, NUM2_INT_W);
  localparam int FRACT_W = max_w(NUM1_FRACT_W, NUM2_FRACT_W);
  localparam int EXT_W   = INT_W + FRACT_W;
  localparam int SH1     = FRACT_W - NUM1_FRACT_W;
  localparam int SH2     = FRACT_W - NUM2_FRACT_W;

  logic signed [EXT_W-1:0] w_a;
  logic signed [EXT_W-1:0] w_b;

  // Sign-extend to the common integer width, then pad fractions on the right.
  assign w_a = EXT_W'($signed(i_num1)) <<< SH1;
  assign w_b = EXT_W'($signed(i_num2)) <<< SH2;

  assign o_res      = (w_a >= w_b);
  assign o_done_pls = i_start_pls;

endmodule

// File: rtl/gen_fip_max_finder.sv
// Sequential arg-max over a valid/ready stream of signed fixed-point samples.
// One comparator is shared across all samples; ties keep the earliest index.
module gen_fip_max_finder
  import gen_fip_max_finder_pkg::*;
#(
  parameter int NUM_INT_W   = 1,
  parameter int NUM_FRACT_W = 5,
  parameter int MAX_LEN     = 16,
  localparam int NUM_W      = NUM_INT_W + NUM_FRACT_W,
  localparam int IDX_W      = $clog2(MAX_LEN)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_start_pls,
  input  logic [IDX_W:0]   i_len,
  input  logic             i_valid,
  input  logic [NUM_W-1:0] i_num,
  output logic             o_ready,
  output logic             o_busy,
  output logic             o_done_pls,
  output logic [NUM_W-1:0] o_max,
  output logic [IDX_W-1:0] o_max_idx
);

  localparam logic [IDX_W:0] LEN_MAX = (IDX_W + 1)'(MAX_LEN);
  localparam logic [IDX_W:0] CNT_ONE = (IDX_W + 1)'(1);

  max_fsm_st_t      r_state;
  max_fsm_st_t      w_state_nxt;
  logic [IDX_W:0]   r_len;
  logic [IDX_W:0]   r_cnt;
  logic [NUM_W-1:0] r_max;
  logic [IDX_W-1:0] r_idx;

  logic             w_accept;
  logic             w_last;
  logic             w_start;
  logic [IDX_W:0]   w_len_clamped;
  logic             w_cmp_res;
  logic             w_cmp_valid;
  logic             w_take_new;

  assign w_accept      = (r_state == ST_RUN) && i_valid;
  assign w_last        = (r_cnt == (r_len - CNT_ONE));
  assign w_start       = (r_state == ST_IDLE) && i_start_pls;
  assign w_len_clamped = (i_len > LEN_MAX) ? LEN_MAX : i_len;

  gen_fip_sign_comperator #(
    .NUM1_INT_W   (NUM_INT_W),
    .NUM1_FRACT_W (NUM_FRACT_W),
    .NUM2_INT_W   (NUM_INT_W),
    .NUM2_FRACT_W (NUM_FRACT_W)
  ) u_cmp (
    .i_start_pls (w_accept),
    .i_num1      (r_max),
    .i_num2      (i_num),
    .o_res       (w_cmp_res),
    .o_done_pls  (w_cmp_valid)
  );

  // o_res==0 means the incoming sample is strictly larger than the current max.
  assign w_take_new = w_cmp_valid && !w_cmp_res;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_start_pls) begin
          w_state_nxt = (w_len_clamped == '0) ? ST_DONE : ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_accept && w_last) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Length, index counter and running maximum.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_len <= '0;
      r_cnt <= '0;
      r_max <= '0;
      r_idx <= '0;
    end else if (w_start) begin
      r_len <= w_len_clamped;
      r_cnt <= '0;
      r_max <= '0;
      r_idx <= '0;
    end else if (w_accept) begin
      r_cnt <= r_cnt + CNT_ONE;
      if (r_cnt == '0) begin
        r_max <= i_num;
        r_idx <= '0;
      end else if (w_take_new) begin
        r_max <= i_num;
        r_idx <= r_cnt[IDX_W-1:0];
      end else begin
        r_max <= r_max;
        r_idx <= r_idx;
      end
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_ready    = (r_state == ST_RUN);
  assign o_busy     = (r_state != ST_IDLE);
  assign o_done_pls = (r_state == ST_DONE);
  assign o_max      = r_max;
  assign o_max_idx  = r_idx;

endmodule

// File: tb/tb_gen_fip_max_finder.sv
// Directed self-checking bench for gen_fip_max_finder with default parameters.
module tb_gen_fip_max_finder;

  logic       clk;
  logic       rstn;
  logic       i_start_pls;
  logic [4:0] i_len;
  logic       i_valid;
  logic [5:0] i_num;
  logic       o_ready;
  logic       o_busy;
  logic       o_done_pls;
  logic [5:0] o_max;
  logic [3:0] o_max_idx;

  logic [5:0] vec [0:19];
  int n_assert;
  int n_fail;
  int n_done;

  gen_fip_max_finder dut (
    .clk         (clk),
    .rstn        (rstn),
    .i_start_pls (i_start_pls),
    .i_len       (i_len),
    .i_valid     (i_valid),
    .i_num       (i_num),
    .o_ready     (o_ready),
    .o_busy      (o_busy),
    .o_done_pls  (o_done_pls),
    .o_max       (o_max),
    .o_max_idx   (o_max_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count done pulses over the whole run.
  always @(posedge clk) begin
    if (o_done_pls === 1'b1) n_done = n_done + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert = n_assert + 1;
    assert (obs === exp) else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start a vector, feed nsamp samples from vec with gap idle cycles before each,
  // then check the done pulse lands right after the last accept.
  task automatic run(input string tag, input int len, input int nsamp, input int gap,
                     input bit mid_start, input logic [5:0] exp_max, input logic [3:0] exp_idx);
    int d0;
    d0 = n_done;
    i_start_pls = 1'b1;
    i_len = 5'(len);
    @(negedge clk);
    i_start_pls = 1'b0;
    chk({tag, "_busy"}, 32'(o_busy), 32'd1);
    for (int i = 0; i < nsamp; i++) begin
      for (int g = 0; g < gap; g++) begin
        i_valid = 1'b0;
        if (mid_start && i == 1 && g == 0) i_start_pls = 1'b1;
        @(negedge clk);
        i_start_pls = 1'b0;
      end
      chk({tag, "_early_done"}, 32'(o_done_pls), 32'd0);
      chk({tag, "_ready"}, 32'(o_ready), 32'd1);
      i_valid = 1'b1;
      i_num = vec[i];
      @(negedge clk);
    end
    i_valid = 1'b0;
    chk({tag, "_done"}, 32'(o_done_pls), 32'd1);
    chk({tag, "_ready_in_done"}, 32'(o_ready), 32'd0);
    chk({tag, "_max"}, 32'(o_max), 32'(exp_max));
    chk({tag, "_idx"}, 32'(o_max_idx), 32'(exp_idx));
    @(negedge clk);
    chk({tag, "_done_low"}, 32'(o_done_pls), 32'd0);
    chk({tag, "_idle"}, 32'(o_busy), 32'd0);
    chk({tag, "_done_count"}, 32'(n_done - d0), 32'd1);
    chk({tag, "_max_held"}, 32'(o_max), 32'(exp_max));
  endtask

  initial begin
    int d0;
    n_assert = 0;
    n_fail = 0;
    n_done = 0;
    rstn = 1'b0;
    i_start_pls = 1'b0;
    i_len = 5'd0;
    i_valid = 1'b0;
    i_num = 6'h00;
    @(negedge clk);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_ready", 32'(o_ready), 32'd0);
    chk("rst_done", 32'(o_done_pls), 32'd0);
    chk("rst_max", 32'(o_max), 32'd0);
    chk("rst_idx", 32'(o_max_idx), 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Valid while idle must be ignored.
    i_valid = 1'b1;
    i_num = 6'h1F;
    @(negedge clk);
    chk("idle_valid_ready", 32'(o_ready), 32'd0);
    chk("idle_valid_busy", 32'(o_busy), 32'd0);
    i_valid = 1'b0;

    vec[0] = 6'h05; vec[1] = 6'h10; vec[2] = 6'h30; vec[3] = 6'h0C;
    run("t1", 4, 4, 0, 1'b0, 6'h10, 4'd1);

    vec[0] = 6'h20; vec[1] = 6'h38; vec[2] = 6'h30;
    run("t2", 3, 3, 0, 1'b0, 6'h38, 4'd1);

    vec[0] = 6'h1F; vec[1] = 6'h00; vec[2] = 6'h1F; vec[3] = 6'h20; vec[4] = 6'h1F;
    run("t3", 5, 5, 0, 1'b0, 6'h1F, 4'd0);

    vec[0] = 6'h20; vec[1] = 6'h38; vec[2] = 6'h30;
    run("t4", 3, 3, 2, 1'b1, 6'h38, 4'd1);

    run("t5_len0", 0, 0, 0, 1'b0, 6'h00, 4'd0);

    for (int i = 0; i < 15; i++) vec[i] = 6'(14 - i);
    vec[15] = 6'h1F;
    run("t5_len16", 16, 16, 0, 1'b0, 6'h1F, 4'd15);

    for (int i = 0; i < 20; i++) vec[i] = 6'h01;
    vec[5] = 6'h1E;
    vec[12] = 6'h1E;
    vec[17] = 6'h1F;
    run("t5_len20", 20, 16, 0, 1'b0, 6'h1E, 4'd5);

    // Reset in the middle of a run aborts without a done pulse.
    vec[0] = 6'h05; vec[1] = 6'h10; vec[2] = 6'h30; vec[3] = 6'h0C;
    d0 = n_done;
    i_start_pls = 1'b1;
    i_len = 5'd4;
    @(negedge clk);
    i_start_pls = 1'b0;
    for (int i = 0; i < 2; i++) begin
      i_valid = 1'b1;
      i_num = vec[i];
      @(negedge clk);
    end
    i_valid = 1'b0;
    chk("t6_busy_before", 32'(o_busy), 32'd1);
    rstn = 1'b0;
    #1;
    chk("t6_busy", 32'(o_busy), 32'd0);
    chk("t6_ready", 32'(o_ready), 32'd0);
    chk("t6_max", 32'(o_max), 32'd0);
    chk("t6_idx", 32'(o_max_idx), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t6_no_done", 32'(n_done - d0), 32'd0);
    chk("t6_idle", 32'(o_busy), 32'd0);
    run("t6_fresh", 4, 4, 0, 1'b0, 6'h10, 4'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
